// File: rtl/clock_div.sv
// rtl/clock_div.sv - divides clkin by 2*HALF_PERIOD into a registered 50 % duty square wave
module clock_div #(
  parameter int HALF_PERIOD = 5000
) (
  input  logic clkin,
  input  logic rst,
  output logic clkout
);

  localparam int CNT_WIDTH = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(HALF_PERIOD - 1);

  if (HALF_PERIOD < 1) begin : g_bad_half_period
    $error("clock_div: HALF_PERIOD must be at least 1");
  end

  // Declaration initialisers give a defined power-up state when rst is tied low.
  logic [CNT_WIDTH-1:0] cnt   = '0;
  logic                 clk_q = 1'b0;

  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt   <= '0;
      clk_q <= 1'b0;
    end else if (cnt == TERMINAL) begin
      cnt   <= '0;
      clk_q <= ~clk_q;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  assign clkout = clk_q;

endmodule

// File: tb/tb_clock_div.sv
// tb/tb_clock_div.sv - randomized scoreboard bench for several clock_div instances
module tb_clock_div;

  localparam int NI = 7;
  localparam int NCYC = 30100;

  typedef struct packed {
    logic [NI-1:0]       out;
    logic [NI-1:0][12:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic [NI-1:0] rst_v = '1;
  logic [NI-1:0] act_out;
  logic [12:0]   act_cnt [NI];

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  function automatic int hp(input int i);
    case (i)
      0: return 3;
      1: return 1;
      2: return 5000;
      3: return 4;
      4: return 4;
      5: return 2;
      default: return 7;
    endcase
  endfunction

  clock_div #(3)                 u_h3   (.clkin(clk), .rst(rst_v[0]), .clkout(act_out[0]));
  clock_div #(.HALF_PERIOD(1))   u_h1   (.clkin(clk), .rst(rst_v[1]), .clkout(act_out[1]));
  clock_div #(.HALF_PERIOD(5000)) u_h5k (.clkin(clk), .rst(1'b0),     .clkout(act_out[2]));
  clock_div #(.HALF_PERIOD(4))   u_h4a  (.clkin(clk), .rst(rst_v[3]), .clkout(act_out[3]));
  clock_div #(.HALF_PERIOD(4))   u_h4b  (.clkin(clk), .rst(rst_v[4]), .clkout(act_out[4]));
  clock_div #(.HALF_PERIOD(2))   u_h2   (.clkin(clk), .rst(rst_v[5]), .clkout(act_out[5]));
  clock_div #(.HALF_PERIOD(7))   u_h7   (.clkin(clk), .rst(rst_v[6]), .clkout(act_out[6]));

  assign act_cnt[0] = 13'(u_h3.cnt);
  assign act_cnt[1] = 13'(u_h1.cnt);
  assign act_cnt[2] = 13'(u_h5k.cnt);
  assign act_cnt[3] = 13'(u_h4a.cnt);
  assign act_cnt[4] = 13'(u_h4b.cnt);
  assign act_cnt[5] = 13'(u_h2.cnt);
  assign act_cnt[6] = 13'(u_h7.cnt);

  // Monitor: one expectation per rising edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          total++;
          if (act_out[i] !== e.out[i]) begin
            bad++;
            $display("FAIL clkout[hp=%0d] t=%0t got=%b want=%b", hp(i), $time, act_out[i], e.out[i]);
          end
          total++;
          if (act_cnt[i] !== e.cnt[i]) begin
            bad++;
            $display("FAIL cnt[hp=%0d] t=%0t got=%0d want=%0d", hp(i), $time, act_cnt[i], e.cnt[i]);
          end
        end
      end
    end
  end

  // Stimulus plus reference model: k = rising edges since reset release,
  // clkout = floor(k/H) mod 2, cnt = k mod H.
  initial begin
    int   k [NI];
    logic [NI-1:0] r;
    bit   h4a_done = 0;
    bit   h4b_done = 0;
    exp_t e;
    for (int i = 0; i < NI; i++) k[i] = 0;

    for (int c = 0; c < NCYC; c++) begin
      if (c != 0) @(negedge clk);
      r = '0;
      for (int i = 0; i < NI; i++) begin
        if (i == 2) continue;
        if (c < 2) r[i] = 1'b1;
        else if (c > 200 && $urandom_range(63) == 0) r[i] = 1'b1;
      end
      // Mid-phase reset on edge 6 while clkout is high.
      if (!h4a_done && c >= 2 && k[3] == 5) begin
        r[3] = 1'b1;
        h4a_done = 1;
      end
      // Reset coinciding with terminal count.
      if (!h4b_done && c >= 2 && k[4] == 7) begin
        r[4] = 1'b1;
        h4b_done = 1;
      end
      if (c > 200 && (k[4] % 4) == 3 && $urandom_range(3) == 0) r[4] = 1'b1;
      rst_v = r;

      for (int i = 0; i < NI; i++) begin
        if (r[i]) k[i] = 0;
        else k[i] = k[i] + 1;
        e.out[i] = 1'((k[i] / hp(i)) % 2);
        e.cnt[i] = 13'(k[i] % hp(i));
      end
      sb_q.push_back(e);
    end

    @(posedge clk);
    #3;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
